// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory arbiter: RAM handshake states, arbiter FSM states,
// default widths and the streak saturation helper.
package cpu_types_pkg;

    localparam int WORD_W           = 32;
    localparam int MAX_D_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // Saturating increment used for the consecutive-data-grant streak.
    function automatic logic [3:0] streak_inc(input logic [3:0] cur, input logic [3:0] lim);
        logic [3:0] res;
        if (cur >= lim) begin
            res = lim;
        end else begin
            res = cur + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// Free-running 32-bit stall counter: counts cycles where inc_i is high, wraps at 2^32,
// cleared by the synchronous active-low reset.
module arb_perf_counter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    // Stall cycle accumulator
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= 32'd0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 32'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter for the single unified RAM port, data-first with a bounded
// streak that forces instruction progress. Optional stall counters under MEM_ARB_PERF_EN.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       i_stall_cnt,
    output logic [31:0]       d_stall_cnt
`endif
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    arb_state_t state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       d_req_s;
    ramstate_t  ram_st_s;

    assign d_req_s  = dREN | dWEN;
    assign ram_st_s = ramstate_t'(ramstate);
    assign iload    = ramload;
    assign dload    = ramload;

    // Grant selection and completion handling; withdraw is checked before ACCESS so a
    // dropped request is never acknowledged.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (d_req_s && (!iREN || (streak_q < STREAK_MAX))) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ram_st_s == ACCESS) begin
                    state_d  = IDLE;
                    streak_d = 4'd0;
                end else if (ram_st_s == ERROR) begin
                    state_d = IDLE;
                end else begin
                    state_d = IGRANT;
                end
            end
            DGRANT: begin
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (ram_st_s == ACCESS) begin
                    state_d  = IDLE;
                    streak_d = iREN ? streak_inc(streak_q, STREAK_MAX) : 4'd0;
                end else if (ram_st_s == ERROR) begin
                    state_d = IDLE;
                end else begin
                    state_d = DGRANT;
                end
            end
            default: begin
                state_d  = IDLE;
                streak_d = 4'd0;
            end
        endcase
    end

    // FSM and streak registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // RAM steering follows the granted requester; enables track the live request so a
    // withdrawal takes effect immediately.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && (ram_st_s == ACCESS)) begin
                    iwait = 1'b0;
                end else begin
                    iwait = 1'b1;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (d_req_s && (ram_st_s == ACCESS)) begin
                    dwait = 1'b0;
                end else begin
                    dwait = 1'b1;
                end
            end
            default: begin
                ramREN = 1'b0;
                ramWEN = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    arb_perf_counter u_i_stall (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc_i (iREN & iwait),
        .cnt_o (i_stall_cnt)
    );

    arb_perf_counter u_d_stall (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc_i (d_req_s & dwait),
        .cnt_o (d_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven cycle bench for mem_arbiter: each record is one cycle of inputs plus the
// expected RAM-side and wait outputs, checked through a scoreboard queue.
module tb_mem_arbiter;

    localparam logic [1:0] FR = 2'd0;
    localparam logic [1:0] BZ = 2'd1;
    localparam logic [1:0] AC = 2'd2;
    localparam logic [1:0] ER = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] i_stall_cnt;
    logic [31:0] d_stall_cnt;
`endif

    mem_arbiter #(.MAX_D_STREAK(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARB_PERF_EN
        ,
        .i_stall_cnt (i_stall_cnt),
        .d_stall_cnt (d_stall_cnt)
`endif
    );

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        iw;
        logic        dw;
        logic [31:0] load;
    } exp_t;

    typedef struct {
        string       name;
        logic        nrst;
        logic        iren;
        logic [31:0] ia;
        logic        dren;
        logic        dwen;
        logic [31:0] da;
        logic [31:0] ds;
        logic [31:0] rl;
        logic [1:0]  rs;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    string names_q[$];
    int n_vec;
    int n_bad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic add(input string nm, input logic nr, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] ds, input logic [31:0] rl, input logic [1:0] rs,
                       input logic er, input logic ew, input logic [31:0] ea,
                       input logic [31:0] es, input logic eiw, input logic edw);
        vec_t v;
        v.name = nm; v.nrst = nr; v.iren = ir; v.ia = ia; v.dren = dr; v.dwen = dw;
        v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
        v.e.ren = er; v.e.wen = ew; v.e.addr = ea; v.e.store = es;
        v.e.iw = eiw; v.e.dw = edw; v.e.load = rl;
        vecs.push_back(v);
    endtask

    // Idle-output shorthand: nothing driven toward RAM, both waits high.
    task automatic add_idle(input string nm, input logic nr, input logic ir, input logic [31:0] ia,
                            input logic dr, input logic dw, input logic [31:0] da,
                            input logic [31:0] ds, input logic [1:0] rs);
        add(nm, nr, ir, ia, dr, dw, da, ds, 32'h0000_0000, rs,
            1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        exp_t act;
        exp_t exp_v;
        string nm;
        n_vec = 0;
        n_bad = 0;

        // Reset held two cycles with an instruction request pending
        add_idle("rst0", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        add_idle("rst1", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        // Instruction fetch: arbitration cycle, then ACCESS
        add_idle("if_arb", 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        add("if_acc", 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8C01_0004, AC,
            1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
        add_idle("if_done", 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        // Contention: data wins first, instruction after
        add_idle("ct_arb", 1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, FR);
        add("ct_dacc", 1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, AC,
            1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0);
        add_idle("ct_arb2", 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        add("ct_iacc", 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_1234, AC,
            1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1);
        add_idle("ct_idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        // Slow RAM: three BUSY cycles before ACCESS
        add_idle("sl_arb", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, FR);
        for (int k = 0; k < 3; k++) begin
            add($sformatf("sl_busy%0d", k), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0,
                32'h0, BZ, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1);
        end
        add("sl_acc", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, AC,
            1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0);
        add_idle("sl_idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        // ERROR mid-grant drops to IDLE without acknowledge, then re-grants
        add_idle("er_arb", 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        add("er_err", 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ER,
            1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1);
        add_idle("er_rearb", 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        add("er_acc", 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_0001, AC,
            1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1);
        add_idle("er_idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        // Read+write collision, then withdraw while BUSY
        add_idle("wd_arb", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h55AA_55AA, FR);
        add("wd_coll", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h55AA_55AA, 32'h0, BZ,
            1'b0, 1'b1, 32'h300, 32'h55AA_55AA, 1'b1, 1'b1);
        add("wd_drop", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 32'h55AA_55AA, 32'h0, BZ,
            1'b0, 1'b0, 32'h300, 32'h55AA_55AA, 1'b1, 1'b1);
        add_idle("wd_noack", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, AC);
        // Starvation guard: four data completions, then instruction is forced
        for (int k = 0; k < 4; k++) begin
            add_idle($sformatf("sv_arb%0d", k), 1'b1, 1'b1, 32'h500, 1'b1, 1'b0,
                     32'h600 + 32'(4 * k), 32'h0, FR);
            add($sformatf("sv_dacc%0d", k), 1'b1, 1'b1, 32'h500, 1'b1, 1'b0,
                32'h600 + 32'(4 * k), 32'h0, 32'h1000 + 32'(k), AC,
                1'b1, 1'b0, 32'h600 + 32'(4 * k), 32'h0, 1'b1, 1'b0);
        end
        add_idle("sv_arb4", 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h700, 32'h0, FR);
        add("sv_iacc", 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h700, 32'h0, 32'h2000, AC,
            1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b1);
        add_idle("sv_arb5", 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h700, 32'h0, FR);
        add("sv_dafter", 1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h700, 32'h0, 32'h3000, AC,
            1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 1'b0);
        add_idle("sv_idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        // Reset asserted mid-grant: enables drop as soon as state is IDLE
        add_idle("mr_arb", 1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, FR);
        add("mr_busy", 1'b0, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, BZ,
            1'b1, 1'b0, 32'h900, 32'h0, 1'b1, 1'b1);
        add_idle("mr_reset", 1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, BZ);
        add("mr_acc", 1'b1, 1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4000, AC,
            1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 1'b1);
        add_idle("mr_idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FR);

        nRST = 1'b0; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FR;

        foreach (vecs[n]) begin
            @(posedge CLK);
            #1;
            nRST = vecs[n].nrst; iREN = vecs[n].iren; iaddr = vecs[n].ia;
            dREN = vecs[n].dren; dWEN = vecs[n].dwen; daddr = vecs[n].da;
            dstore = vecs[n].ds; ramload = vecs[n].rl; ramstate = vecs[n].rs;
            sb.push_back(vecs[n].e);
            names_q.push_back(vecs[n].name);
            @(negedge CLK);
            exp_v = sb.pop_front();
            nm = names_q.pop_front();
            act.ren = ramREN; act.wen = ramWEN; act.addr = ramaddr; act.store = ramstore;
            act.iw = iwait; act.dw = dwait; act.load = iload;
            n_vec++;
            if (act !== exp_v || dload !== exp_v.load) begin
                n_bad++;
                $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b iload=%h dload=%h; want ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b load=%h",
                         nm, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
                         exp_v.ren, exp_v.wen, exp_v.addr, exp_v.store, exp_v.iw, exp_v.dw,
                         exp_v.load);
            end
            if (n > 0 && vecs[n-1].nrst === 1'b0) begin
                if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s reset-state: ramREN=%b ramWEN=%b iwait=%b dwait=%b, want 0 0 1 1",
                             nm, ramREN, ramWEN, iwait, dwait);
                end
            end
            if ((iwait === 1'b0 || dwait === 1'b0) && ramstate !== AC) begin
                n_bad++;
                $display("FAIL %s expired-wait: iwait=%b dwait=%b dropped with ramstate=%0d",
                         nm, iwait, dwait, ramstate);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
